vga_timing_receiver: RTL and testbench

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

---
 rtl/vga_timing_receiver.sv | 266 ++++++++++++++++++++++++++
 tb/tb_vga_timing_receiver.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver.
// Registers the incoming sync/blank/colour once, recovers horizontal and
// vertical position from the sync falling edges, and locks onto the stream
// after one complete, correctly sized frame. While locked, active-window
// pixels are presented with their (x, y) coordinates. Timing errors are
// counted, and a sticky flag reports BLANK_N disagreeing with the expected
// window.
//
// Output handshake: pix_valid is a qualifier, not a handshake. There is no
// ready; the receiver never stalls. x, y and pix_r/g/b are meaningful only
// in the cycle pix_valid is high, and hold their last values otherwise.
//
// Position convention: the first input clock with hsync low is h position 0.
// hcnt_d / vcnt_d are the position of the pixel currently held in the
// input stage. The output registers load from them, so a pixel reaches the
// outputs two clocks after it is presented at the inputs.
module vga_timing_receiver #(
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_hsync,
  input  logic       vga_vsync,
  input  logic       sync_blank,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       pix_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] pix_r,
  output logic [7:0] pix_g,
  output logic [7:0] pix_b,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count,
  output logic       blank_err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START_L = 10'(H_START);
  localparam logic [9:0] H_END_L   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_START_L = 10'(V_START);
  localparam logic [9:0] V_END_L   = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX   = 10'h3FF;

  // Input stage
  logic       hsync_s1_q, hsync_s1_d;
  logic       vsync_s1_q, vsync_s1_d;
  logic       blank_s1_q, blank_s1_d;
  logic [7:0] red_s1_q, red_s1_d;
  logic [7:0] green_s1_q, green_s1_d;
  logic [7:0] blue_s1_q, blue_s1_d;
  logic       hsync_prev_q, hsync_prev_d;
  logic       vsync_prev_q, vsync_prev_d;

  // Position tracking
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       pending_q, pending_d;

  // Control
  state_t     state_q, state_d;
  logic       locked_q, locked_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] err_count_q, err_count_d;
  logic       blank_err_q, blank_err_d;

  // Pixel outputs
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] pix_r_q, pix_r_d;
  logic [7:0] pix_g_q, pix_g_d;
  logic [7:0] pix_b_q, pix_b_d;

  // Events decoded from the input stage
  logic hs_fall;
  logic vs_fall;
  logic frame_ev;
  logic line_err;
  logic frame_err;
  logic in_window;
  logic err_inc;
  logic fs_pulse;

  // Input capture, edge detection, counters and the pixel datapath
  always_comb begin
    hsync_s1_d   = vga_hsync;
    vsync_s1_d   = vga_vsync;
    blank_s1_d   = sync_blank;
    red_s1_d     = red;
    green_s1_d   = green;
    blue_s1_d    = blue;
    hsync_prev_d = hsync_s1_q;
    vsync_prev_d = vsync_s1_q;

    hs_fall  = ~hsync_s1_q & hsync_prev_q;
    vs_fall  = ~vsync_s1_q & vsync_prev_q;
    // A vsync edge may arrive with or before the hsync edge that opens line 0.
    frame_ev = hs_fall & (pending_q | vs_fall);

    // Both error checks look at the count before it is reloaded.
    line_err  = hs_fall & (hcnt_q != H_LAST);
    frame_err = frame_ev & (vcnt_q != V_LAST);

    hcnt_d = hcnt_q;
    if (hs_fall) begin
      hcnt_d = 10'd0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    vcnt_d = vcnt_q;
    if (frame_ev) begin
      vcnt_d = 10'd0;
    end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    pending_d = pending_q;
    if (frame_ev) begin
      pending_d = 1'b0;
    end else if (vs_fall) begin
      pending_d = 1'b1;
    end

    in_window = (hcnt_d >= H_START_L) && (hcnt_d < H_END_L) &&
                (vcnt_d >= V_START_L) && (vcnt_d < V_END_L);

    pix_valid_d = locked_q & in_window;
    x_d     = x_q;
    y_d     = y_q;
    pix_r_d = pix_r_q;
    pix_g_d = pix_g_q;
    pix_b_d = pix_b_q;
    if (pix_valid_d) begin
      x_d     = hcnt_d - H_START_L;
      y_d     = vcnt_d - V_START_L;
      pix_r_d = red_s1_q;
      pix_g_d = green_s1_q;
      pix_b_d = blue_s1_q;
    end

    blank_err_d = blank_err_q | (locked_q & (blank_s1_q != in_window));
  end

  // Lock FSM: next state, error counting and frame_start generation
  always_comb begin
    state_d  = state_q;
    err_inc  = 1'b0;
    fs_pulse = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (frame_ev) begin
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        // Any bad line aborts immediately, so reaching the frame edge here
        // means the whole frame was clean; only its length remains to check.
        if (line_err) begin
          state_d = ST_SEARCH;
        end else if (frame_ev) begin
          state_d = frame_err ? ST_SEARCH : ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (line_err || frame_err) begin
          state_d = ST_SEARCH;
          err_inc = 1'b1;
        end else if (frame_ev) begin
          fs_pulse = 1'b1;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = fs_pulse;
  end

  // State register with synchronous reset; syncs idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_s1_q    <= 1'b1;
      vsync_s1_q    <= 1'b1;
      blank_s1_q    <= 1'b0;
      red_s1_q      <= 8'd0;
      green_s1_q    <= 8'd0;
      blue_s1_q     <= 8'd0;
      hsync_prev_q  <= 1'b1;
      vsync_prev_q  <= 1'b1;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      pending_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_count_q   <= 8'd0;
      blank_err_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pix_r_q       <= 8'd0;
      pix_g_q       <= 8'd0;
      pix_b_q       <= 8'd0;
    end else begin
      hsync_s1_q    <= hsync_s1_d;
      vsync_s1_q    <= vsync_s1_d;
      blank_s1_q    <= blank_s1_d;
      red_s1_q      <= red_s1_d;
      green_s1_q    <= green_s1_d;
      blue_s1_q     <= blue_s1_d;
      hsync_prev_q  <= hsync_prev_d;
      vsync_prev_q  <= vsync_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pending_q     <= pending_d;
      state_q       <= state_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      err_count_q   <= err_count_d;
      blank_err_q   <= blank_err_d;
      pix_valid_q   <= pix_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err_count   = err_count_q;
  assign blank_err   = blank_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a shrunken raster:
// 12 clocks/line (active 3..8), 6 lines/frame (active 2..4),
// hsync low for h positions 0..1, vsync low for lines 0..1.
module tb_vga_timing_receiver;

  localparam int HT = 12;
  localparam int HS = 3;
  localparam int HA = 6;
  localparam int VT = 6;
  localparam int VS = 2;
  localparam int VA = 3;

  logic       clk;
  logic       rst;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       sync_blank;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       pix_valid;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       locked;
  logic       frame_start;
  logic [7:0] err_count;
  logic       blank_err;
  logic [1:0] dbg_state;

  vga_timing_receiver #(
    .H_TOTAL (HT),
    .H_START (HS),
    .H_ACTIVE(HA),
    .V_TOTAL (VT),
    .V_START (VS),
    .V_ACTIVE(VA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .sync_blank (sync_blank),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_valid  (pix_valid),
    .x          (x),
    .y          (y),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .locked     (locked),
    .frame_start(frame_start),
    .err_count  (err_count),
    .blank_err  (blank_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int origin_cyc   = 0;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt = 0;
  int         fs_cnt    = 0;
  logic       prev_valid = 1'b0;
  int         first_cyc = 0;
  logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
  logic [7:0] first_r = '0, first_g = '0, first_b = '0;
  logic [7:0] last_r = '0, last_g = '0, last_b = '0;

  always @(negedge clk) begin
    if (pix_valid) begin
      valid_cnt = valid_cnt + 1;
      last_x = x; last_y = y;
      last_r = pix_r; last_g = pix_g; last_b = pix_b;
      if (!prev_valid) begin
        first_cyc = cyc;
        first_x = x; first_y = y;
        first_r = pix_r; first_g = pix_g; first_b = pix_b;
      end
    end
    if (frame_start) fs_cnt = fs_cnt + 1;
    prev_valid = pix_valid;
  end

  // ---------------- colour model ----------------
  function automatic logic [7:0] col_r(input int p, input int l);
    return 8'(p * 3 + 1);
  endfunction
  function automatic logic [7:0] col_g(input int p, input int l);
    return 8'(l * 5 + 2 + p * 0);
  endfunction
  function automatic logic [7:0] col_b(input int p, input int l);
    return 8'((p * 16 + l) ^ 8'h5a);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pix(input int p, input int l, input bit force_blank_low);
    @(negedge clk);
    vga_hsync  = (p < 2) ? 1'b0 : 1'b1;
    vga_vsync  = (l < 2) ? 1'b0 : 1'b1;
    sync_blank = (p >= HS) && (p < HS + HA) && (l >= VS) && (l < VS + VA) && !force_blank_low;
    red   = col_r(p, l);
    green = col_g(p, l);
    blue  = col_b(p, l);
    if (p == HS && l == VS) origin_cyc = cyc;
  endtask

  task automatic drive_line(input int l, input int len, input int from_p);
    for (int p = from_p; p < len; p++) drive_pix(p, l, 1'b0);
  endtask

  task automatic drive_frame(input int n_lines);
    for (int l = 0; l < n_lines; l++) drive_line(l, HT, 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  int fs0;
  int vbase;

  initial begin
    rst = 1'b1;
    vga_hsync = 1'b1; vga_vsync = 1'b1; sync_blank = 1'b0;
    red = '0; green = '0; blue = '0;
    repeat (3) @(negedge clk);

    check("rst_pix_valid",   32'(pix_valid),   0);
    check("rst_x",           32'(x),           0);
    check("rst_y",           32'(y),           0);
    check("rst_rgb",         32'({pix_r, pix_g, pix_b}), 0);
    check("rst_locked",      32'(locked),      0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_err_count",   32'(err_count),   0);
    check("rst_blank_err",   32'(blank_err),   0);
    check("rst_state",       32'(dbg_state),   0);
    rst = 1'b0;

    // Frame A: first frame-start event moves SEARCH -> ALIGN.
    drive_frame(VT);
    check("a_locked", 32'(locked), 0);
    check("a_state",  32'(dbg_state), 1);

    // Frame B: second frame-start event locks.
    fs0 = fs_cnt;
    drive_line(0, HT, 0);
    check("b_locked",   32'(locked), 1);
    check("b_state",    32'(dbg_state), 2);
    check("b_no_fs",    32'(fs_cnt - fs0), 0);
    vbase = valid_cnt;
    drive_line(1, HT, 0);
    drive_line(2, HT, 0);
    check("first_x",    32'(first_x), 0);
    check("first_y",    32'(first_y), 0);
    check("first_r",    32'(first_r), 32'(col_r(HS, VS)));
    check("first_g",    32'(first_g), 32'(col_g(HS, VS)));
    check("first_b",    32'(first_b), 32'(col_b(HS, VS)));
    check("latency",    32'(first_cyc - origin_cyc), 2);
    for (int l = 3; l < VT; l++) drive_line(l, HT, 0);
    check("valid_per_frame", 32'(valid_cnt - vbase), 32'(HA * VA));
    check("last_x", 32'(last_x), 5);
    check("last_y", 32'(last_y), 2);
    check("last_rgb", 32'({last_r, last_g, last_b}),
          32'({col_r(8, 4), col_g(8, 4), col_b(8, 4)}));
    check("hold_valid", 32'(pix_valid), 0);
    check("hold_x",     32'(x), 5);
    check("hold_y",     32'(y), 2);
    check("hold_r",     32'(pix_r), 32'(col_r(8, 4)));

    // Frame C: clean frame while locked pulses frame_start once.
    fs0 = fs_cnt;
    drive_frame(VT);
    check("c_fs_pulses", 32'(fs_cnt - fs0), 1);
    check("c_err_count", 32'(err_count), 0);
    check("c_blank_err", 32'(blank_err), 0);
    check("c_locked",    32'(locked), 1);

    // Frame D: line 3 is one clock short; error seen at line 4 hsync fall.
    drive_line(0, HT, 0);
    drive_line(1, HT, 0);
    drive_line(2, HT, 0);
    drive_line(3, HT - 1, 0);
    drive_pix(0, 4, 1'b0);
    drive_pix(1, 4, 1'b0);
    check("d_locked_before", 32'(locked), 1);
    drive_pix(2, 4, 1'b0);
    check("d_locked_after",  32'(locked), 0);
    check("d_err_count",     32'(err_count), 1);
    check("d_state",         32'(dbg_state), 0);
    drive_line(4, HT, 3);
    drive_line(5, HT, 0);

    // Frames E, F: relock after two clean frame starts.
    drive_line(0, HT, 0);
    check("e_locked", 32'(locked), 0);
    check("e_state",  32'(dbg_state), 1);
    for (int l = 1; l < VT; l++) drive_line(l, HT, 0);
    drive_line(0, HT, 0);
    check("f_locked", 32'(locked), 1);
    for (int l = 1; l < VT; l++) drive_line(l, HT, 0);
    check("f_err_count", 32'(err_count), 1);

    // Frame G is one line short; frame H start sees the frame error.
    drive_frame(VT - 1);
    fs0 = fs_cnt;
    drive_line(0, HT, 0);
    check("h_locked",    32'(locked), 0);
    check("h_err_count", 32'(err_count), 2);
    check("h_no_fs",     32'(fs_cnt - fs0), 0);
    for (int l = 1; l < VT; l++) drive_line(l, HT, 0);
    drive_frame(VT);
    drive_line(0, HT, 0);
    check("j_locked", 32'(locked), 1);

    // Frame J: BLANK_N forced low at x=2 y=1 (h 5, line 3).
    drive_line(1, HT, 0);
    drive_line(2, HT, 0);
    check("blank_err_before", 32'(blank_err), 0);
    for (int p = 0; p < HT; p++) drive_pix(p, 3, p == 5);
    check("blank_err_set", 32'(blank_err), 1);
    drive_line(4, HT, 0);
    drive_line(5, HT, 0);
    drive_frame(VT);
    check("blank_err_sticky", 32'(blank_err), 1);
    check("blank_err_count",  32'(err_count), 2);

    // Frame L: reset mid-line while locked.
    drive_line(0, HT, 0);
    drive_line(1, HT, 0);
    drive_line(2, HT, 0);
    drive_line(3, 6, 0);
    check("l_valid_pre_rst", 32'(pix_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_pix_valid", 32'(pix_valid), 0);
    check("mrst_xy",        32'({x, y}), 0);
    check("mrst_rgb",       32'({pix_r, pix_g, pix_b}), 0);
    check("mrst_locked",    32'(locked), 0);
    check("mrst_fs",        32'(frame_start), 0);
    check("mrst_err_count", 32'(err_count), 0);
    check("mrst_blank_err", 32'(blank_err), 0);
    vbase = valid_cnt;
    drive_line(3, HT, 6);
    drive_line(4, HT, 0);
    drive_line(5, HT, 0);
    drive_frame(VT);
    check("mrst_no_valid", 32'(valid_cnt - vbase), 0);
    check("mrst_unlocked", 32'(locked), 0);
    drive_line(0, HT, 0);
    check("mrst_relock", 32'(locked), 1);
    for (int l = 1; l < VT; l++) drive_line(l, HT, 0);

    // Repeated errors: short line 0 while locked, then a clean frame to re-align.
    for (int i = 0; i < 255; i++) begin
      drive_line(0, HT - 1, 0);
      for (int l = 1; l < VT; l++) drive_line(l, HT, 0);
      drive_frame(VT);
    end
    check("err_count_255", 32'(err_count), 255);
    for (int i = 0; i < 5; i++) begin
      drive_line(0, HT - 1, 0);
      for (int l = 1; l < VT; l++) drive_line(l, HT, 0);
      drive_frame(VT);
    end
    check("err_count_sat", 32'(err_count), 255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
